datapath_param: RTL and testbench

- Parametrised successor to the 4-bit datapath.
- Generalises data width and scratch-memory depth.
- Adds a richer ALU with carry/zero flags, register moves, memory load into any register, and an instruction-valid qualifier.
- Sits between the microcode sequencer (which drives instr/instr_valid) and the shared output bus.

---
 rtl/datapath_param.sv | 117 +++++++++++
 tb/tb_datapath_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_param.sv
// Parametrised datapath: A/B/R registers, ALU with carry/zero, scratch memory, registered bus.
// Executes one instruction per valid edge; memory is read combinationally so a load sees the prior edge's store.
module datapath_param #(
    parameter int DW = 4,
    parameter int AW = 4,
    localparam int IW = DW + 4
) (
    input  logic          clk,
    input  logic          grst,
    input  logic          instr_valid,
    input  logic [IW-1:0] instr,
    output logic [DW-1:0] bus,
    output logic          carry,
    output logic          zero
);

    logic          m;
    logic          w;
    logic [1:0]    sel;
    logic [DW-1:0] field;
    logic [3:0]    op;
    logic [AW-1:0] addr;

    assign m     = instr[IW-1];
    assign sel   = instr[IW-2:IW-3];
    assign w     = instr[IW-4];
    assign field = instr[DW-1:0];
    assign op    = field[3:0];
    assign addr  = field[AW-1:0];

    logic [DW-1:0] a, b, r;
    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] mem_rd;
    logic [DW-1:0] src;

    assign mem_rd = mem[addr];

    always_comb begin
        case (sel)
            2'b01:   src = a;
            2'b10:   src = b;
            default: src = r;
        endcase
    end

    logic [DW:0]   sum;
    logic [DW-1:0] alu_r;
    logic          alu_c;
    logic          alu_en;

    // ADD and ADC share one DW+1-bit adder; only ADC folds in the old carry.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b} + ((op == 4'hB) ? (DW+1)'(carry) : '0);
        alu_r  = '0;
        alu_c  = 1'b0;
        alu_en = 1'b0;
        case (op)
            4'h1, 4'hB: begin alu_r = sum[DW-1:0]; alu_c = sum[DW]; alu_en = 1'b1; end
            4'h2: begin alu_r = a - b;  alu_c = (a < b); alu_en = 1'b1; end
            4'h3: begin alu_r = a & b;  alu_en = 1'b1; end
            4'h4: begin alu_r = a | b;  alu_en = 1'b1; end
            4'h5: begin alu_r = a ^ b;  alu_en = 1'b1; end
            4'hC: begin alu_r = {a[DW-2:0], 1'b0}; alu_c = a[DW-1]; alu_en = 1'b1; end
            4'hD: begin alu_r = {1'b0, a[DW-1:1]}; alu_c = a[0];    alu_en = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            a     <= '0;
            b     <= '0;
            r     <= '0;
            bus   <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (instr_valid) begin
            if (!m) begin
                if (sel != 2'b00) begin
                    case (sel)
                        2'b01:   a <= field;
                        2'b10:   b <= field;
                        default: r <= field;
                    endcase
                end else begin
                    if (alu_en) begin
                        r     <= alu_r;
                        carry <= alu_c;
                        zero  <= (alu_r == '0);
                    end
                    case (op)
                        4'h6:    a   <= r;
                        4'h7:    b   <= r;
                        4'h8:    bus <= a;
                        4'h9:    bus <= b;
                        4'hA:    bus <= r;
                        default: ;
                    endcase
                end
            end else if (!w) begin
                case (sel)
                    2'b01:   a <= mem_rd;
                    2'b10:   b <= mem_rd;
                    2'b11:   r <= mem_rd;
                    default: ;
                endcase
            end
        end
    end

    // Memory has no reset so its contents survive grst; writes are suppressed while grst is high.
    always_ff @(posedge clk) begin
        if (instr_valid && !grst && m && w && (sel != 2'b00))
            mem[addr] <= src;
    end

endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench for datapath_param at DW=4 and DW=8 using directed instruction vectors.
module tb_datapath_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        grst = 1'b1;
    logic        v4 = 1'b0, v8 = 1'b0;
    logic [7:0]  i4 = '0;
    logic [11:0] i8 = '0;
    logic [3:0]  bus4;
    logic [7:0]  bus8;
    logic        c4, z4, c8, z8;

    datapath_param #(.DW(4), .AW(4)) dut4 (
        .clk(clk), .grst(grst), .instr_valid(v4), .instr(i4),
        .bus(bus4), .carry(c4), .zero(z4)
    );

    datapath_param #(.DW(8), .AW(4)) dut8 (
        .clk(clk), .grst(grst), .instr_valid(v8), .instr(i8),
        .bus(bus8), .carry(c8), .zero(z8)
    );

    typedef struct {
        int         dut;
        logic [7:0] bus;
        logic       c;
        logic       z;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic chk = 1'b0;

    localparam logic [1:0] SA = 2'b01, SB = 2'b10, SR = 2'b11;

    function automatic logic [11:0] mk(int dw, logic m, logic [1:0] s, logic w, logic [7:0] f);
        logic [11:0] hi;
        hi = {8'b0, m, s, w};
        return (hi << dw) | {4'b0, f};
    endfunction

    function automatic logic [11:0] li(int dw, logic [1:0] s, logic [7:0] v);
        return mk(dw, 1'b0, s, 1'b0, v);
    endfunction

    function automatic logic [11:0] opc(int dw, logic [3:0] o);
        return mk(dw, 1'b0, 2'b00, 1'b0, {4'b0, o});
    endfunction

    function automatic logic [11:0] st(int dw, logic [1:0] s, logic [7:0] ad);
        return mk(dw, 1'b1, s, 1'b1, ad);
    endfunction

    function automatic logic [11:0] ld(int dw, logic [1:0] s, logic [7:0] ad);
        return mk(dw, 1'b1, s, 1'b0, ad);
    endfunction

    task automatic step(input int d, input logic [11:0] ins, input bit v, input bit c,
                        input logic [7:0] eb, input logic ec, input logic ez, input string nm);
        @(negedge clk);
        if (d == 0) begin i4 = ins[7:0]; v4 = v; v8 = 1'b0; end
        else        begin i8 = ins;      v8 = v; v4 = 1'b0; end
        chk = c;
        if (c) exp_q.push_back('{dut: d, bus: eb, c: ec, z: ez, name: nm});
    endtask

    task automatic x4(input logic [11:0] ins);
        step(0, ins, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "");
    endtask

    task automatic n4(input logic [11:0] ins);
        step(0, ins, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "");
    endtask

    task automatic o4(input logic [11:0] ins, input logic [7:0] eb, input logic ec,
                      input logic ez, input string nm);
        step(0, ins, 1'b1, 1'b1, eb, ec, ez, nm);
    endtask

    task automatic x8(input logic [11:0] ins);
        step(1, ins, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "");
    endtask

    task automatic o8(input logic [11:0] ins, input logic [7:0] eb, input logic ec,
                      input logic ez, input string nm);
        step(1, ins, 1'b1, 1'b1, eb, ec, ez, nm);
    endtask

    // Monitor: compares the executing edge's result against the queued expectation.
    always @(posedge clk) begin : mon
        exp_t       e;
        logic [7:0] ab;
        logic       ac, az;
        if (chk) begin
            #1;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_underflow: got a check with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if (e.dut == 0) begin ab = {4'b0, bus4}; ac = c4; az = z4; end
                else            begin ab = bus8;         ac = c8; az = z8; end
                if (ab !== e.bus || ac !== e.c || az !== e.z) begin
                    fails++;
                    $display("FAIL %s: got bus=%0d carry=%0b zero=%0b, expected bus=%0d carry=%0b zero=%0b",
                             e.name, ab, ac, az, e.bus, e.c, e.z);
                end
            end
        end
    end

    initial begin
        // Reset with random valid instructions presented.
        for (int k = 0; k < 2; k++) begin
            step(0, 12'($urandom), 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, "reset_dw4");
            step(1, 12'($urandom), 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, "reset_dw8");
        end
        @(negedge clk);
        chk = 1'b0; v4 = 1'b0; v8 = 1'b0; grst = 1'b0;
        o4(opc(4, 4'h8), 8'd0, 1'b0, 1'b0, "reset_out_a");
        o4(opc(4, 4'h9), 8'd0, 1'b0, 1'b0, "reset_out_b");
        o4(opc(4, 4'hA), 8'd0, 1'b0, 1'b0, "reset_out_r");

        // Load and add.
        x4(li(4, SA, 8'd2)); x4(li(4, SB, 8'd5)); x4(opc(4, 4'h1));
        o4(opc(4, 4'hA), 8'd7, 1'b0, 1'b0, "add_2_5");
        x4(li(4, SA, 8'd9)); x4(li(4, SB, 8'd8)); x4(opc(4, 4'h1));
        o4(opc(4, 4'hA), 8'd1, 1'b1, 1'b0, "add_9_8_carry");
        x4(li(4, SA, 8'd0)); x4(li(4, SB, 8'd0)); x4(opc(4, 4'hB));
        o4(opc(4, 4'hA), 8'd1, 1'b0, 1'b0, "adc_carry_in");

        // Subtract, shifts and logic.
        x4(li(4, SA, 8'd7)); x4(li(4, SB, 8'd6)); x4(opc(4, 4'h2));
        o4(opc(4, 4'hA), 8'd1, 1'b0, 1'b0, "sub_7_6");
        x4(li(4, SA, 8'd6)); x4(li(4, SB, 8'd7)); x4(opc(4, 4'h2));
        o4(opc(4, 4'hA), 8'd15, 1'b1, 1'b0, "sub_6_7_borrow");
        x4(li(4, SA, 8'd5)); x4(li(4, SB, 8'd5)); x4(opc(4, 4'h2));
        o4(opc(4, 4'hA), 8'd0, 1'b0, 1'b1, "sub_zero");
        x4(li(4, SA, 8'd9)); x4(opc(4, 4'hC));
        o4(opc(4, 4'hA), 8'd2, 1'b1, 1'b0, "shl_9");
        x4(opc(4, 4'hD));
        o4(opc(4, 4'hA), 8'd4, 1'b1, 1'b0, "shr_9");
        x4(li(4, SA, 8'hC)); x4(li(4, SB, 8'hA)); x4(opc(4, 4'h3));
        o4(opc(4, 4'hA), 8'h8, 1'b0, 1'b0, "and");
        x4(opc(4, 4'h4));
        o4(opc(4, 4'hA), 8'hE, 1'b0, 1'b0, "or");
        x4(opc(4, 4'h5));
        o4(opc(4, 4'hA), 8'h6, 1'b0, 1'b0, "xor");
        x4(opc(4, 4'h6));
        o4(opc(4, 4'h8), 8'h6, 1'b0, 1'b0, "mov_r_a");
        x4(opc(4, 4'h7));
        o4(opc(4, 4'h9), 8'h6, 1'b0, 1'b0, "mov_r_b");

        // Memory, including retention across a mid-sequence reset.
        x4(li(4, SR, 8'd7)); x4(st(4, SR, 8'd0)); x4(li(4, SR, 8'd3));
        x4(ld(4, SB, 8'd0));
        o4(opc(4, 4'h9), 8'd7, 1'b0, 1'b0, "load_mem0_b");
        @(negedge clk);
        chk = 1'b0; v4 = 1'b0; grst = 1'b1;
        #1;
        tests++;
        if (bus4 !== 4'd0) begin
            fails++;
            $display("FAIL async_reset_bus: got bus=%0d, expected bus=0", bus4);
        end
        @(negedge clk);
        grst = 1'b0;
        x4(ld(4, SA, 8'd0));
        o4(opc(4, 4'h8), 8'd7, 1'b0, 1'b0, "mem_kept_over_reset");
        x4(li(4, SA, 8'd5)); x4(st(4, SA, 8'hF));
        x4(li(4, SA, 8'hA)); x4(st(4, SA, 8'hF)); x4(ld(4, SB, 8'hF));
        o4(opc(4, 4'h9), 8'hA, 1'b0, 1'b0, "store_then_load_f");

        // Instruction-valid qualifier.
        x4(li(4, SA, 8'd1)); x4(li(4, SB, 8'd2)); x4(li(4, SR, 8'd9));
        x4(st(4, SB, 8'd1));
        o4(opc(4, 4'h8), 8'd1, 1'b0, 1'b0, "qual_setup_out_a");
        n4(opc(4, 4'h2)); n4(li(4, SA, 8'hF)); n4(st(4, SA, 8'd1)); n4(opc(4, 4'hA));
        o4(opc(4, 4'h0), 8'd1, 1'b0, 1'b0, "qual_bus_flags_held");
        o4(opc(4, 4'hA), 8'd9, 1'b0, 1'b0, "qual_r_held");
        o4(opc(4, 4'h8), 8'd1, 1'b0, 1'b0, "qual_a_held");
        x4(ld(4, SA, 8'd1));
        o4(opc(4, 4'h8), 8'd2, 1'b0, 1'b0, "qual_mem_held");

        // Width generality on the DW=8 instance.
        x8(li(8, SA, 8'd200)); x8(li(8, SB, 8'd100)); x8(opc(8, 4'h1));
        o8(opc(8, 4'hA), 8'd44, 1'b1, 1'b0, "dw8_add_200_100");
        x8(st(8, SR, 8'd15)); x8(ld(8, SA, 8'd15));
        o8(opc(8, 4'h8), 8'd44, 1'b1, 1'b0, "dw8_mem15_roundtrip");
        x8(opc(8, 4'hD));
        o8(opc(8, 4'hA), 8'd22, 1'b0, 1'b0, "dw8_shr");

        @(negedge clk);
        chk = 1'b0; v4 = 1'b0; v8 = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
